// File: rtl/tdm_pkg.sv
// Shared definitions for the 8-lane TDM serializer: lane count, slot-select
// width and the frame FSM state encoding.
package tdm_pkg;

  localparam int NUM_LANES = 8;
  localparam int SEL_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tdm_state_e;

endpackage

// File: rtl/mux8to1.sv
// Combinational lane selector: picks one bit of the captured frame by slot.
module mux8to1
  import tdm_pkg::*;
(
  input  logic [NUM_LANES-1:0] i_data,
  input  logic [SEL_W-1:0]     i_sel,
  output logic                 o_d
);

  assign o_d = i_data[i_sel];

endmodule

// File: rtl/tdm_mux8_tx.sv
// TDM transmitter: captures 8 parallel lanes and sends them one slot at a
// time on d with a 3-bit slot select, each slot held for HOLD cycles.
module tdm_mux8_tx
  import tdm_pkg::*;
#(
  parameter int HOLD = 1,
  parameter bit CONT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] i,
  input  logic                 start,
  input  logic                 en,
  output logic                 d,
  output logic                 s0,
  output logic                 s1,
  output logic                 s2,
  output logic                 valid,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           o_dbg_state
);

  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

  tdm_state_e           r_state;
  logic [NUM_LANES-1:0] r_shadow;
  logic [SEL_W-1:0]     r_sel;
  logic [3:0]           r_hold;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;

  logic w_go;
  logic w_capture;
  logic w_mux_d;

  // DONE doubles as a capture point so back-to-back frames leave a single gap cycle.
  assign w_go      = CONT ? en : start;
  assign w_capture = w_go && ((r_state == IDLE) || (r_state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_sel    <= '0;
      r_hold   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (w_capture) begin
      r_state  <= SEND;
      r_shadow <= i;
      r_sel    <= '0;
      r_hold   <= '0;
      r_valid  <= 1'b1;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
        end
        SEND: begin
          if (r_hold == HOLD_M1) begin
            r_hold <= '0;
            if (r_sel == SEL_W'(NUM_LANES - 1)) begin
              r_state <= DONE;
              r_sel   <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_sel <= r_sel + 3'd1;
            end
          end else begin
            r_hold <= r_hold + 4'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  mux8to1 u_mux (
    .i_data (r_shadow),
    .i_sel  (r_sel),
    .o_d    (w_mux_d)
  );

  // The shadow keeps the last frame after it ends, so the line is gated off outside slots.
  assign d           = w_mux_d & r_valid;
  assign s0          = r_sel[0];
  assign s1          = r_sel[1];
  assign s2          = r_sel[2];
  assign valid       = r_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule
